// File: rtl/uart_tx_fifo.sv
// Circular byte buffer that feeds UART_TX one word at a time.
// Each word stays stored until UART_TX reports it sent.
module uart_tx_fifo #(
    parameter int unsigned BITS       = 8,
    parameter int unsigned DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [BITS-1:0]       wr_data,
    output logic                  full,
    output logic                  empty,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  overflow,
    output logic [BITS-1:0]       tx_data,
    output logic                  tx_data_ready,
    input  logic                  tx_data_sent
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_COUNT = {1'b1, {DEPTH_LOG2{1'b0}}};

    typedef enum logic [1:0] {IDLE, PRESENT, WAIT_SENT, GAP} state_t;

    state_t                 state, state_next;
    logic [BITS-1:0]        mem [DEPTH];
    logic [DEPTH_LOG2-1:0]  head, tail;
    logic                   push, pop, load, ready_next;
    logic [DEPTH_LOG2:0]    count_next;

    always_comb begin
        state_next = state;
        ready_next = tx_data_ready;
        load       = 1'b0;
        pop        = 1'b0;
        case (state)
            IDLE: begin
                ready_next = 1'b0;
                if (!empty) begin
                    load       = 1'b1;
                    ready_next = 1'b1;
                    state_next = PRESENT;
                end
            end
            PRESENT: begin
                ready_next = 1'b1;
                state_next = WAIT_SENT;
            end
            WAIT_SENT: begin
                ready_next = 1'b1;
                if (tx_data_sent) begin
                    pop        = 1'b1;
                    ready_next = 1'b0;
                    state_next = GAP;
                end
            end
            GAP: begin
                ready_next = 1'b0;
                state_next = IDLE;
            end
            default: begin
                ready_next = 1'b0;
                state_next = IDLE;
            end
        endcase
    end

    // full is the registered flag, so a write coinciding with a pop while full is still dropped
    always_comb begin
        push = wr_en && !full;
        case ({push, pop})
            2'b10:   count_next = count + 1'b1;
            2'b01:   count_next = count - 1'b1;
            default: count_next = count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[tail] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            head          <= '0;
            tail          <= '0;
            count         <= '0;
            full          <= 1'b0;
            empty         <= 1'b1;
            overflow      <= 1'b0;
            tx_data       <= '0;
            tx_data_ready <= 1'b0;
        end else begin
            state         <= state_next;
            tx_data_ready <= ready_next;
            count         <= count_next;
            full          <= (count_next == FULL_COUNT);
            empty         <= (count_next == '0);
            if (push) begin
                tail <= tail + 1'b1;
            end
            if (pop) begin
                head <= head + 1'b1;
            end
            if (wr_en && full) begin
                overflow <= 1'b1;
            end
            if (load) begin
                tx_data <= mem[head];
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: acts as UART_TX and checks against a queue-based reference model.
module tb_uart_tx_fifo;

    localparam int BITS  = 8;
    localparam int DL    = 4;
    localparam int DEPTH = 16;

    logic            clk = 1'b0;
    logic            rst;
    logic            wr_en;
    logic [BITS-1:0] wr_data;
    logic            full, empty, overflow, tx_data_ready, tx_data_sent;
    logic [DL:0]     count;
    logic [BITS-1:0] tx_data;

    always #5 clk = ~clk;

    uart_tx_fifo #(.BITS(BITS), .DEPTH_LOG2(DL)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data),
        .full(full), .empty(empty), .count(count), .overflow(overflow),
        .tx_data(tx_data), .tx_data_ready(tx_data_ready), .tx_data_sent(tx_data_sent)
    );

    int errors = 0;
    int checks = 0;

    // Reference model: stored words in order, sticky overflow, and how long ready has been seen high/low.
    byte unsigned q[$];
    bit           m_ovf;
    int           ready_run;
    int           low_run;

    typedef struct {
        logic            w;
        logic [BITS-1:0] d;
        logic            s;
        int              c;
        logic            r;
        logic [BITS-1:0] x;
    } vec_t;

    vec_t tbl[18];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock: drive inputs, predict the edge from the model, then sample and compare.
    task automatic step(input logic w, input logic [BITS-1:0] d, input logic s);
        bit do_push;
        bit do_pop;
        wr_en        = w;
        wr_data      = d;
        tx_data_sent = s;
        do_push = w && (q.size() < DEPTH);
        do_pop  = s && (ready_run >= 2);
        if (w && !do_push) m_ovf = 1'b1;
        if (do_pop) begin
            check("pop_nonempty", q.size() > 0, 1);
            if (q.size() > 0) check("pop_data", tx_data, q[0]);
        end
        @(posedge clk);
        #1;
        wr_en        = 1'b0;
        tx_data_sent = 1'b0;
        if (do_pop && q.size() > 0) void'(q.pop_front());
        if (do_push) q.push_back(d);
        check("count", count, q.size());
        check("empty", empty, q.size() == 0);
        check("full", full, q.size() == DEPTH);
        check("overflow", overflow, m_ovf);
        if (tx_data_ready) begin
            check("ready_nonempty", q.size() > 0, 1);
            if (q.size() > 0) check("tx_data", tx_data, q[0]);
            ready_run++;
            low_run = 0;
        end else begin
            ready_run = 0;
            if (q.size() > 0) low_run++;
            else low_run = 0;
            check("ready_stall", low_run <= 2, 1);
        end
    endtask

    // Reset is applied between edges; outputs must clear without any clock edge.
    task automatic do_reset();
        rst = 1'b1;
        #2;
        check("rst_count", count, 0);
        check("rst_empty", empty, 1);
        check("rst_full", full, 0);
        check("rst_overflow", overflow, 0);
        check("rst_ready", tx_data_ready, 0);
        check("rst_tx_data", tx_data, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        q.delete();
        m_ovf     = 1'b0;
        ready_run = 0;
        low_run   = 0;
    endtask

    task automatic drain(input int budget);
        for (int i = 0; i < budget && q.size() > 0; i++) begin
            step(1'b0, '0, ready_run >= 2);
        end
        check("drain_timeout", q.size(), 0);
    endtask

    initial begin
        rst          = 1'b0;
        wr_en        = 1'b0;
        wr_data      = '0;
        tx_data_sent = 1'b0;
        m_ovf        = 1'b0;
        ready_run    = 0;
        low_run      = 0;

        tbl[0]  = '{1'b1, 8'h55, 1'b0, 1, 1'b0, 8'h00};
        tbl[1]  = '{1'b0, 8'h00, 1'b0, 1, 1'b1, 8'h55};
        tbl[2]  = '{1'b0, 8'h00, 1'b0, 1, 1'b1, 8'h55};
        tbl[3]  = '{1'b0, 8'h00, 1'b1, 0, 1'b0, 8'h55};
        tbl[4]  = '{1'b0, 8'h00, 1'b1, 0, 1'b0, 8'h55};
        tbl[5]  = '{1'b0, 8'h00, 1'b1, 0, 1'b0, 8'h55};
        tbl[6]  = '{1'b1, 8'hCC, 1'b0, 1, 1'b0, 8'h55};
        tbl[7]  = '{1'b0, 8'h00, 1'b1, 1, 1'b1, 8'hCC};
        tbl[8]  = '{1'b0, 8'h00, 1'b1, 1, 1'b1, 8'hCC};
        tbl[9]  = '{1'b0, 8'h00, 1'b1, 0, 1'b0, 8'hCC};
        tbl[10] = '{1'b1, 8'hA5, 1'b0, 1, 1'b0, 8'hCC};
        tbl[11] = '{1'b1, 8'h0F, 1'b0, 2, 1'b1, 8'hA5};
        tbl[12] = '{1'b0, 8'h00, 1'b0, 2, 1'b1, 8'hA5};
        tbl[13] = '{1'b0, 8'h00, 1'b1, 1, 1'b0, 8'hA5};
        tbl[14] = '{1'b1, 8'h11, 1'b1, 2, 1'b0, 8'hA5};
        tbl[15] = '{1'b0, 8'h00, 1'b0, 2, 1'b1, 8'h0F};
        tbl[16] = '{1'b1, 8'h22, 1'b0, 3, 1'b1, 8'h0F};
        tbl[17] = '{1'b1, 8'h33, 1'b1, 3, 1'b0, 8'h0F};

        @(posedge clk);
        #1;
        do_reset();

        // Latency, spurious data_sent in every non-waiting state, gap timing, coincident push/pop.
        for (int i = 0; i < 18; i++) begin
            step(tbl[i].w, tbl[i].d, tbl[i].s);
            check($sformatf("vec%0d_count", i), count, tbl[i].c);
            check($sformatf("vec%0d_ready", i), tx_data_ready, tbl[i].r);
            check($sformatf("vec%0d_tx_data", i), tx_data, tbl[i].x);
        end
        drain(100);

        // Fill to 16 with data_sent held low, then one dropped write.
        do_reset();
        for (int i = 0; i < DEPTH; i++) begin
            step(1'b1, 8'(i * 7 + 3), 1'b0);
        end
        check("fill_full", full, 1);
        check("fill_count", count, DEPTH);
        check("fill_ovf_before", overflow, 0);
        step(1'b1, 8'hEE, 1'b0);
        check("drop_ovf", overflow, 1);
        check("drop_count", count, DEPTH);
        step(1'b1, 8'hEF, 1'b0);
        drain(200);
        check("ovf_sticky", overflow, 1);

        // Writes timed to coincide with data_sent, carrying pointers well past wrap.
        do_reset();
        for (int i = 0; i < 3; i++) step(1'b1, 8'($urandom), 1'b0);
        begin
            int coinc = 0;
            for (int i = 0; i < 400 && coinc < 40; i++) begin
                if (ready_run >= 2) begin
                    step(1'b1, 8'($urandom), 1'b1);
                    coinc++;
                end else begin
                    step(1'b0, '0, 1'b0);
                end
            end
            check("coincident_budget", coinc, 40);
        end
        drain(200);

        // Random traffic with varying write pressure and stray data_sent pulses.
        do_reset();
        for (int chunk = 0; chunk < 6; chunk++) begin
            int wp;
            wp = 15 + chunk * 15;
            for (int i = 0; i < 100; i++) begin
                logic w, s;
                w = ($urandom_range(0, 99) < wp);
                if (ready_run >= 2) s = ($urandom_range(0, 2) == 0);
                else s = ($urandom_range(0, 7) == 0);
                step(w, 8'($urandom), s);
            end
        end

        // Reset while a word is being presented.
        begin
            int t = 0;
            while (!tx_data_ready && t < 50) begin
                step(q.size() == 0, 8'h5A, 1'b0);
                t++;
            end
            check("mid_reset_ready_seen", tx_data_ready, 1);
        end
        do_reset();
        step(1'b0, '0, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
